// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the set-bit scanner.
package bit_scan_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IDX_W = 5;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMPTY = 2'd2
    } state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc32.sv
// Combinational priority encoder: index of the lowest set bit plus a found flag.
module prio_enc32 (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        found
);

    always_comb begin
        idx   = '0;
        found = |vec;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[4:0];
            end
        end
    end

endmodule

// File: rtl/bit_scan_unit.sv
// Sequential set-bit scanner emitting one bit index per beat, LSB- or MSB-first.
// Optional out_count (population count of the accepted mask) with BIT_SCAN_COUNT_EN.
module bit_scan_unit
    import bit_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_empty,
    output logic             busy
`ifdef BIT_SCAN_COUNT_EN
    ,output logic [IDX_W:0]  out_count
`endif
);

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic             dir_q;

    logic [WIDTH-1:0] rem_rev;
    logic [WIDTH-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;
    logic [IDX_W-1:0] scan_idx;
    logic             single;
    logic             accept;
    logic             beat;

    always_comb begin
        rem_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rem_rev[i] = rem_q[WIDTH-1-i];
        end
    end

    // MSB-first reuses the LSB encoder on the reversed word and mirrors the index.
    assign enc_in = (dir_q == DIR_MSB) ? rem_rev : rem_q;

    prio_enc32 u_enc (
        .vec   (enc_in),
        .idx   (enc_idx),
        .found (enc_found)
    );

    assign scan_idx = (dir_q == DIR_MSB) ? (IDX_W'(WIDTH - 1) - enc_idx) : enc_idx;
    assign single   = ((rem_q & (rem_q - WIDTH'(1))) == '0);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_empty = (state_q == ST_EMPTY);
    assign out_idx   = (state_q == ST_SCAN) ? scan_idx : '0;

    always_comb begin
        out_last = 1'b0;
        case (state_q)
            ST_SCAN:  out_last = enc_found && single;
            ST_EMPTY: out_last = 1'b1;
            default:  out_last = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign beat   = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dir_q   <= DIR_LSB;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rem_q   <= in_mask;
                        dir_q   <= in_dir;
                        state_q <= (in_mask != '0) ? ST_SCAN : ST_EMPTY;
                    end
                end
                ST_SCAN: begin
                    if (beat) begin
                        rem_q <= rem_q & ~(WIDTH'(1) << scan_idx);
                        if (out_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_EMPTY: begin
                    if (beat) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BIT_SCAN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_count <= '0;
        end else if (accept) begin
            out_count <= (IDX_W+1)'(popcount32(in_mask));
        end
    end
`endif

endmodule

// File: tb/tb_bit_scan_unit.sv
// Scoreboard bench for bit_scan_unit: directed masks, expected beats queued, monitor compares.
module tb_bit_scan_unit;

    typedef struct {
        logic [4:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mask;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        out_empty;
    logic        busy;
`ifdef BIT_SCAN_COUNT_EN
    logic [5:0]  out_count;
`endif

    beat_t exp_q[$];
    int    total  = 0;
    int    passed = 0;

    bit         prev_stall = 1'b0;
    logic [4:0] prev_idx;
    logic       prev_last;
    logic       prev_empty;

    always #5 clk = ~clk;

    bit_scan_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_empty (out_empty),
        .busy      (busy)
`ifdef BIT_SCAN_COUNT_EN
        ,.out_count (out_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input int idx, input bit last, input bit empty);
        beat_t b;
        b.idx   = idx[4:0];
        b.last  = last;
        b.empty = empty;
        exp_q.push_back(b);
    endtask

    // Monitor: samples on the falling edge, pops an expected beat per handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_idx",   {27'd0, out_idx},   {27'd0, prev_idx});
                chk("stall_last",  {31'd0, out_last},  {31'd0, prev_last});
                chk("stall_empty", {31'd0, out_empty}, {31'd0, prev_empty});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {27'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_idx",   {27'd0, out_idx},   {27'd0, e.idx});
                    chk("beat_last",  {31'd0, out_last},  {31'd0, e.last});
                    chk("beat_empty", {31'd0, out_empty}, {31'd0, e.empty});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_last  = out_last;
            prev_empty = out_empty;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) chk("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_mask(input logic [31:0] m, input logic d, input int exp_busy,
                            input bit toggle, input int exp_cnt);
        int n;
        wait_ready();
        in_valid  = 1'b1;
        in_mask   = m;
        in_dir    = d;
        out_ready = toggle ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mask  = 32'hDEAD_BEEF;
        in_dir   = ~d;
        chk("valid_n1", {31'd0, out_valid}, 32'd1);
`ifdef BIT_SCAN_COUNT_EN
        if (exp_cnt >= 0) chk("count_n1", {26'd0, out_count}, exp_cnt);
`endif
        n = 0;
        while (!in_ready && n < 300) begin
            n++;
            if (toggle) out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        if (n >= 300) chk("scan_timeout", 32'd0, 32'd1);
        else if (exp_busy >= 0) chk("busy_cycles", n, exp_busy);
        chk("drain", exp_q.size(), 32'd0);
`ifdef BIT_SCAN_COUNT_EN
        if (exp_cnt >= 0) chk("count_held", {26'd0, out_count}, exp_cnt);
`endif
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst_idx",   {27'd0, out_idx},   32'd0);
        chk("rst_last",  {31'd0, out_last},  32'd0);
        chk("rst_empty", {31'd0, out_empty}, 32'd0);
`ifdef BIT_SCAN_COUNT_EN
        chk("rst_count", {26'd0, out_count}, 32'd0);
`endif

        // 0x91 LSB-first: bits 0,4,7
        push_exp(0, 0, 0); push_exp(4, 0, 0); push_exp(7, 1, 0);
        run_mask(32'h0000_0091, 1'b0, 3, 1'b0, 3);

        // Same mask MSB-first
        push_exp(7, 0, 0); push_exp(4, 0, 0); push_exp(0, 1, 0);
        run_mask(32'h0000_0091, 1'b1, 3, 1'b0, 3);

        // Zero mask: single empty beat
        push_exp(0, 1, 1);
        run_mask(32'h0000_0000, 1'b0, 1, 1'b0, 0);

        // All ones with out_ready toggling
        for (int i = 0; i < 32; i++) push_exp(i, (i == 31), 0);
        run_mask(32'hFFFF_FFFF, 1'b0, -1, 1'b1, 32);

        // MSB-first over a sparse high/low mask
        push_exp(31, 0, 0); push_exp(1, 1, 0);
        run_mask(32'h8000_0002, 1'b1, 2, 1'b0, 2);

        // Population count mask: bits 16..19, 24..27
        for (int i = 16; i < 20; i++) push_exp(i, 0, 0);
        for (int i = 24; i < 28; i++) push_exp(i, (i == 27), 0);
        run_mask(32'h0F0F_0000, 1'b0, 8, 1'b0, 8);

        // Reset mid-scan after the first beat
        wait_ready();
        push_exp(0, 0, 0);
        in_valid  = 1'b1;
        in_mask   = 32'h8000_0003;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_first_popped", exp_q.size(), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid2", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy",   {31'd0, busy},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_no_beats", {31'd0, out_valid}, 32'd0);
        end
        push_exp(2, 1, 0);
        run_mask(32'h0000_0004, 1'b0, 1, 1'b0, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
